// File: rtl/uart_ctrl_pkg.sv
// Shared types and parameter defaults for the UART transmit scheduler.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  localparam int unsigned GAP_CYCLES_DEFAULT  = 16;
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester found after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NUM_W = (ID_W + 1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] pick;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    pick   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum  = {1'b0, last_grant} + (ID_W + 1)'(k);
      pick = (sum >= NUM_W) ? ID_W'(sum - NUM_W) : sum[ID_W-1:0];
      if (req[pick]) begin
        winner = pick;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grant,
// start pulse, acknowledge timeout and an enforced inter-frame gap.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       active,
  output logic                       err_timeout
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  // A zero-length gap still spends one clock in GAP.
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [7:0]         ack_cnt_q, ack_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               tx_start_q, tx_start_d;
  logic               err_q, err_d;
  logic               active_q, active_d;
  logic [ID_W-1:0]    winner;
  logic               win_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .last_grant(last_grant_q),
    .winner    (winner),
    .valid     (win_valid)
  );

  always_comb begin
    // NOTE: every _d starts from its hold/idle value so no branch can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    tx_data_d    = tx_data_q;
    ack_cnt_d    = ack_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    gnt_d        = '0;
    tx_start_d   = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (win_valid && !tx_busy) begin
          state_d        = S_LOAD;
          gnt_d[winner]  = 1'b1;
          tx_data_d      = req_data[{winner, 3'b000} +: 8];
          cur_id_d       = winner;
          last_grant_d   = winner;
        end
      end
      S_LOAD: begin
        state_d    = S_START;
        tx_start_d = 1'b1;
      end
      S_START: begin
        state_d   = S_WAIT_ACK;
        ack_cnt_d = '0;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = S_GAP;
          err_d     = 1'b1;
          gap_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= '0;
      tx_data_q    <= '0;
      ack_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      gnt_q        <= '0;
      tx_start_q   <= 1'b0;
      err_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      tx_data_q    <= tx_data_d;
      ack_cnt_q    <= ack_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      gnt_q        <= gnt_d;
      tx_start_q   <= tx_start_d;
      err_q        <= err_d;
      active_q     <= active_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign cur_id      = cur_id_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scenario bench for uart_tx_scheduler with a behavioural transmitter and a
// round-robin reference model; a second instance covers GAP_CYCLES=0.
module tb_uart_tx_scheduler;
  localparam int unsigned N   = 4;
  localparam int unsigned GAP = 16;
  localparam int unsigned ACK = 8;
  localparam int unsigned IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [IDW-1:0] cur_id;
  logic           active;
  logic           err_timeout;
  logic           model_busy = 1'b0;
  logic           force_busy = 1'b0;

  logic [N-1:0]   req2 = '0;
  logic [8*N-1:0] req_data2 = '0;
  logic [N-1:0]   gnt2;
  logic [7:0]     tx_data2;
  logic           tx_start2;
  logic           busy2 = 1'b0;
  logic [IDW-1:0] cur_id2;
  logic           active2;
  logic           err_timeout2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_delay = 1;   // 0 = transmitter never acknowledges
  int frame_len = 4;
  int dly = 0;
  int len = 0;
  int busy_fall_cyc = -1;

  assign tx_busy = model_busy | force_busy;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .cur_id(cur_id),
    .active(active), .err_timeout(err_timeout)
  );

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(0), .ACK_TIMEOUT(ACK)) dut_gap0 (
    .clk(clk), .reset(reset), .req(req2), .req_data(req_data2), .gnt(gnt2),
    .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(busy2), .cur_id(cur_id2),
    .active(active2), .err_timeout(err_timeout2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises ack_delay clocks after tx_start, stays frame_len clocks.
  always @(negedge clk) begin
    if (reset) begin
      model_busy = 1'b0;
      dly = 0;
      len = 0;
    end else if (tx_start && ack_delay > 0) begin
      dly = ack_delay;
      len = frame_len;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) model_busy = 1'b1;
    end else if (len > 0) begin
      len--;
      if (len == 0) begin
        model_busy    = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; req2 = '0; force_busy = 1'b0; busy2 = 1'b0;
    ack_delay = 1; frame_len = 4;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_gnt(input int budget, output int id, output int at);
    id = -1; at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (gnt !== '0) begin
        id = onehot_idx(gnt); at = cyc;
        return;
      end
    end
    errors++; checks++;
    $display("FAIL wait_gnt: no grant within %0d clocks, required one", budget);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'b1111; req_data = 32'hDEADBEEF;
    repeat (3) tick();
    checks++; if (gnt !== '0)          begin errors++; $display("FAIL reset_gnt: got %b required 0", gnt); end
    checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err_timeout); end
    checks++; if (active !== 1'b0)     begin errors++; $display("FAIL reset_active: got %b required 0", active); end
    checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    checks++; if (cur_id !== '0)       begin errors++; $display("FAIL reset_cur_id: got %0d required 0", cur_id); end
    req = '0;
  endtask

  task automatic test_single;
    do_reset();
    req_data[7:0] = 8'h41; req = 4'b0001;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL s1_idle_active: got %b required 0", active); end
    tick();  // decision clock done: LOAD
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL s1_gnt: got %b required 0001", gnt); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL s1_tx_data: got %h required 41", tx_data); end
    checks++; if (cur_id !== 2'd0) begin errors++; $display("FAIL s1_cur_id: got %0d required 0", cur_id); end
    req = '0; req_data[7:0] = 8'hEE;
    tick();  // START: third clock counting the request clock
    checks++; if (tx_start !== 1'b1 || gnt !== '0) begin
      errors++; $display("FAIL s1_tx_start: got start=%b gnt=%b required start=1 gnt=0000", tx_start, gnt);
    end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL s1_data_hold: got %h required 41", tx_data); end
  endtask

  task automatic test_round_robin;
    int id, at, last, exp;
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    last = N - 1;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(100, id, at);
      exp = rr_pick(last, 4'b1111);
      checks++; if (id != exp) begin errors++; $display("FAIL s2_order[%0d]: got %0d required %0d", f, id, exp); end
      checks++; if (tx_data !== 8'(8'h10 + exp)) begin
        errors++; $display("FAIL s2_data[%0d]: got %h required %h", f, tx_data, 8'(8'h10 + exp));
      end
      // busy low on clock f, then GAP clocks of gap, then the IDLE decision clock
      if (f > 0) begin
        checks++; if (at - busy_fall_cyc != int'(GAP) + 2) begin
          errors++; $display("FAIL s2_gap[%0d]: got %0d required %0d", f, at - busy_fall_cyc, GAP + 2);
        end
      end
      last = exp;
      if (id >= 0) req[id] = 1'b0;
      tick();
      if (id >= 0) req[id] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_timeout;
    int id, at, s, e;
    do_reset();
    ack_delay = 0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
    req = 4'b0101;
    wait_gnt(10, id, at);
    checks++; if (id != 0) begin errors++; $display("FAIL s3_first: got %0d required 0", id); end
    req[0] = 1'b0;
    s = -1; e = -1;
    for (int i = 0; i < 40 && e < 0; i++) begin
      tick();
      if (tx_start === 1'b1) begin s = cyc; ack_delay = 1; end
      if (err_timeout === 1'b1) e = cyc;
    end
    // ACK WAIT_ACK clocks follow START; the pulse shows on the clock after them
    checks++; if (s < 0 || e != s + int'(ACK) + 1) begin
      errors++; $display("FAIL s3_timeout_cycle: got %0d required %0d", e - s, ACK + 1);
    end
    tick();
    checks++; if (err_timeout !== 1'b0 || active !== 1'b1) begin
      errors++; $display("FAIL s3_err_width: got err=%b active=%b required err=0 active=1", err_timeout, active);
    end
    while (cyc < e + int'(GAP)) tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL s3_idle: got active=%b required 0", active); end
    tick();
    checks++; if (gnt !== 4'b0100 || tx_data !== 8'hA2) begin
      errors++; $display("FAIL s3_pending: got gnt=%b data=%h required 0100 a2", gnt, tx_data);
    end
    req = '0;
  endtask

  task automatic test_reset_midframe;
    int id, at;
    do_reset();
    frame_len = 30;
    req_data = {8'h04, 8'h77, 8'h02, 8'h01};
    req = 4'b0100;
    wait_gnt(10, id, at);
    checks++; if (id != 2) begin errors++; $display("FAIL s4_first: got %0d required 2", id); end
    req = '0;
    for (int i = 0; i < 20 && tx_busy !== 1'b1; i++) tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++; if ({gnt, tx_start, err_timeout, active} !== '0) begin
      errors++; $display("FAIL s4_reset_ctrl: got gnt=%b start=%b err=%b active=%b required all 0",
                         gnt, tx_start, err_timeout, active);
    end
    checks++; if (tx_data !== 8'h00 || cur_id !== '0) begin
      errors++; $display("FAIL s4_reset_regs: got data=%h id=%0d required 00 0", tx_data, cur_id);
    end
    reset = 1'b0;
    req = 4'b1111;
    wait_gnt(10, id, at);
    checks++; if (id != 0 || tx_data !== 8'h01) begin
      errors++; $display("FAIL s4_after_reset: got id=%0d data=%h required 0 01", id, tx_data);
    end
    req = '0;
  endtask

  task automatic test_busy_idle;
    int bad = 0;
    do_reset();
    force_busy = 1'b1;
    req_data[23:16] = 8'h5C; req = 4'b0100;
    repeat (10) begin tick(); if (gnt !== '0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL s5_held_off: got %0d grant clocks required 0", bad); end
    force_busy = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL s5_gnt: got %b required 0100", gnt); end
    req = '0;
  endtask

  task automatic test_pulse_gap0;
    int bad = 0;
    bit started = 1'b0;
    do_reset();
    req_data2[7:0] = 8'h31; req2 = 4'b0001;
    for (int i = 0; i < 10 && !started; i++) begin
      tick();
      if (gnt2 !== '0) req2 = '0;
      if (tx_start2 === 1'b1) started = 1'b1;
    end
    checks++; if (!started) begin errors++; $display("FAIL s6_start: got no tx_start required one"); end
    busy2 = 1'b1;
    repeat (4) tick();
    req_data2[15:8] = 8'h99; req2 = 4'b0010;
    tick();
    req2 = '0;
    repeat (2) tick();
    busy2 = 1'b0;
    tick();
    checks++; if (active2 !== 1'b1) begin errors++; $display("FAIL s6_gap_cycle: got active=%b required 1", active2); end
    tick();
    checks++; if (active2 !== 1'b0) begin errors++; $display("FAIL s6_gap_len: got active=%b required 0", active2); end
    repeat (20) begin tick(); if (gnt2 !== '0 || tx_start2 !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL s6_no_extra: got %0d bad clocks required 0", bad); end
  endtask

  task automatic test_random;
    logic [N-1:0] mask = '0, prev_mask = '0, exp_gnt;
    logic [7:0]   dat [N];
    int last = N - 1, exp, served = 0, exp_err = 0, seen_err = 0, excl_bad = 0, guard = 0;
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    while (served < 40 && guard < 20000) begin
      tick(); guard++;
      if (int'(gnt !== '0) + int'(tx_start === 1'b1) + int'(err_timeout === 1'b1) > 1) excl_bad++;
      if (err_timeout === 1'b1) seen_err++;
      if (gnt !== '0) begin
        exp = rr_pick(last, prev_mask);
        exp_gnt = '0;
        if (exp >= 0) exp_gnt[exp] = 1'b1;
        checks++; if (gnt !== exp_gnt) begin
          errors++; $display("FAIL rnd_gnt[%0d]: got %b required %b", served, gnt, exp_gnt);
        end
        if (exp >= 0) begin
          checks++; if (tx_data !== dat[exp] || cur_id !== IDW'(exp)) begin
            errors++; $display("FAIL rnd_data[%0d]: got %h/%0d required %h/%0d", served, tx_data, cur_id, dat[exp], exp);
          end
          mask[exp] = 1'b0;
          last = exp;
        end
        served++;
        if ($urandom_range(0, 5) == 0) begin ack_delay = 0; exp_err++; end
        else ack_delay = $urandom_range(1, ACK);
        frame_len = $urandom_range(1, 6);
      end
      for (int i = 0; i < N; i++)
        if (!mask[i] && $urandom_range(0, 15) == 0) begin mask[i] = 1'b1; dat[i] = 8'($urandom); end
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
      req = mask;
      prev_mask = mask;
    end
    checks++; if (served < 40) begin errors++; $display("FAIL rnd_progress: got %0d frames required 40", served); end
    req = '0;
    repeat (60) begin
      tick();
      if (err_timeout === 1'b1) seen_err++;
      if (gnt !== '0) excl_bad++;
    end
    checks++; if (seen_err != exp_err) begin errors++; $display("FAIL rnd_timeouts: got %0d required %0d", seen_err, exp_err); end
    checks++; if (excl_bad != 0) begin errors++; $display("FAIL rnd_exclusive: got %0d bad clocks required 0", excl_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_midframe();
    test_busy_idle();
    test_pulse_gap0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
